// File: rtl/adder_share_ctrl_pkg.sv
// Shared-adder controller types: FSM state encoding and default operand/sum widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_ctrl_pkg;

    localparam int OP_W_DEF  = 4;
    localparam int SUM_W_DEF = OP_W_DEF + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Request, adder and response signals between clients, the controller and the shared adder.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready per requester, resp_valid/resp_ready on the response.
interface adder_share_ctrl_if
    import adder_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int OP_W = OP_W_DEF,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*OP_W-1:0] req_a;
    logic [NREQ*OP_W-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic [OP_W-1:0]      add_a;
    logic [OP_W-1:0]      add_b;
    logic [OP_W:0]        add_sum;
    logic                 resp_valid;
    logic [IDW-1:0]       resp_id;
    logic [OP_W:0]        resp_sum;
    logic                 resp_ready;
    logic                 busy;

    modport master (
        output req_valid, req_a, req_b, add_sum, resp_ready,
        input  req_ready, add_a, add_b, resp_valid, resp_id, resp_sum, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, add_sum, resp_ready,
        output req_ready, add_a, add_b, resp_valid, resp_id, resp_sum, busy
    );

endinterface

// File: rtl/adder_share_ctrl_arb.sv
// Round-robin arbiter: first requester after last_i (wrapping) wins.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is taken.
module adder_rr_arb
    import adder_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [NREQ-1:0] gnt_oh_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            any_req_o
);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_req_o = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last_i) + k) % NREQ);
            if (!any_req_o && req_i[idx]) begin
                any_req_o      = 1'b1;
                gnt_idx_o      = idx;
                gnt_oh_o[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one registered adder among NREQ requesters, one operation in flight.
// Latency: accept in cycle T, resp_valid from T+ADD_LAT+1; issue period ADD_LAT+2.
// Backpressure: RESP holds all outputs until resp_ready; req_ready only while IDLE.
module adder_share_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int OP_W    = OP_W_DEF,
    parameter int ADD_LAT = 1,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic               ck,
    input  logic               rst,
    adder_share_ctrl_if.slave  bus
);

    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    ctrl_state_e      state_q;
    logic [OP_W-1:0]  add_a_q;
    logic [OP_W-1:0]  add_b_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   last_q;
    logic [CNT_W-1:0] cnt_q;
    logic             resp_valid_q;
    logic             busy_q;

    logic [NREQ-1:0]  gnt_oh;
    logic [IDW-1:0]   gnt_idx;
    logic             any_req;
    logic [OP_W-1:0]  sel_a_d;
    logic [OP_W-1:0]  sel_b_d;

    adder_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i     (bus.req_valid),
        .last_i    (last_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .any_req_o (any_req)
    );

    assign sel_a_d = bus.req_a[int'(gnt_idx)*OP_W +: OP_W];
    assign sel_b_d = bus.req_b[int'(gnt_idx)*OP_W +: OP_W];

    // Gated by rst so no accept strobe is shown while reset is held.
    assign bus.req_ready  = (state_q == IDLE && !rst) ? gnt_oh : '0;
    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_sum   = bus.add_sum;
    assign bus.busy       = busy_q;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            add_a_q      <= '0;
            add_b_q      <= '0;
            id_q         <= '0;
            last_q       <= IDW'(NREQ - 1);
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        add_a_q <= sel_a_d;
                        add_b_q <= sel_b_d;
                        id_q    <= gnt_idx;
                        last_q  <= gnt_idx;
                        cnt_q   <= CNT_W'(ADD_LAT - 1);
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule
